core_ex_bjp_resolve: RTL
========================

CORE_EX_BJP_RESOLVE -- requirements
Module: core_ex_bjp_resolve

Interface
REQ-001 SHALL have ports: clk  in  1  core clock, all state on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: i_valid  in  1  branch-op request valid; i_ready  out  1  request accepted when i_valid&i_ready.
REQ-004 SHALL have ports: i_pc  in  XLEN  op PC; i_flag_jal, i_flag_jalr, i_flag_branch  in  1 each  op class from fetch pre-decode; i_bj_imm  in  XLEN  sign-extended B/J/I immediate.
REQ-005 SHALL have ports: i_funct3  in  3  branch condition; i_rs1, i_rs2  in  XLEN  operands; i_pred_pc  in  XLEN  next PC predicted at fetch.
REQ-006 SHALL have ports: o_redirect_valid  out  1; o_redirect_pc  out  XLEN; i_redirect_ready  in  1  fetch accepts redirect.
REQ-007 SHALL have ports: o_flush  out  1  one-cycle squash of younger ops; o_res_valid  out  1; o_res_taken  out  1; o_res_link  out  XLEN  PC+4 for rd; o_misalign  out  1.
REQ-008 SHALL have ports: o_cnt_branch, o_cnt_mispred  out  32 each  performance counters.

Function
REQ-009 SHALL implement FSM IDLE, WAIT; i_ready=1 only in IDLE.
REQ-010 SHALL ignore accepted requests with no flag set: no result, no counter change.
REQ-011 SHALL resolve flag priority jal > jalr > branch when several flags are set.
REQ-012 SHALL treat jal and jalr as always taken; branch taken per funct3: 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU; 010/011 not taken.
REQ-013 SHALL compute target = i_pc+i_bj_imm for jal/branch and (i_rs1+i_bj_imm) with bit0 cleared for jalr; all adds modulo 2^XLEN, wrap ignored.
REQ-014 SHALL compute actual next PC = taken ? target : i_pc+4; mispredict = actual != i_pred_pc.
REQ-015 SHALL register results with latency 1: o_res_valid pulses for one cycle after acceptance, carrying o_res_taken, o_res_link=i_pc+4, and o_misalign=taken&target[1].
REQ-016 SHALL, on mispredict, assert o_redirect_valid, o_redirect_pc=actual next PC, and a one-cycle o_flush in the cycle after acceptance, then enter WAIT.
REQ-017 SHALL hold o_redirect_valid and o_redirect_pc stable in WAIT until i_redirect_ready is high; the handshake completes in that cycle, and the FSM returns to IDLE next cycle.
REQ-018 SHALL complete the handshake in the first cycle of assertion, with no WAIT stall beyond that cycle, if i_redirect_ready is already high.
REQ-019 SHALL issue redirect with o_misalign=1 when misaligned; exception handling is downstream.
REQ-020 SHALL increment o_cnt_branch per resolved op, and o_cnt_mispred per mispredict, in the same cycle as o_res_valid; both saturate at 32'hFFFF_FFFF.
REQ-021 SHALL drive o_flush only once per redirect, never during WAIT cycles.

Reset
REQ-022 SHALL on rst_n low, immediately and regardless of FSM state, set FSM=IDLE, all outputs 0 (i_ready becomes 1 with IDLE), counters 0, pending redirect dropped.
REQ-023 SHALL accept the first request in the first clock edge after rst_n deasserts.

Structure
REQ-024 SHALL take CORE_XLEN, funct3 codes and FSM state encodings from shared core_defines.v.
REQ-025 SHALL place the funct3 compare in one sub-module core_bjp_cmp (rs1, rs2, funct3 -> taken); all sequential logic stays in the top.

Verification
REQ-026 SHALL cover: BEQ pc=0x100, imm=0x20, rs1=rs2=5, pred=0x104 -> next cycle o_redirect_pc=0x120, o_flush=1, o_res_taken=1, cnt_mispred=1.
REQ-027 SHALL cover: BLT rs1=0xFFFFFFFF, rs2=1, pc=0x200, imm=0x40, pred=0x240 -> taken, no redirect, cnt_branch+1 only; BLTU same operands -> not taken, redirect 0x204.
REQ-028 SHALL cover: JALR rs1=0x1001, imm=0x4, pc=0x300, pred=0x304 -> redirect 0x1004, o_res_link=0x304, o_misalign=0.
REQ-029 SHALL cover: mispredict with i_redirect_ready low for 3 cycles -> o_redirect_valid held 4 cycles, i_ready=0 throughout, single o_flush pulse, new i_valid accepted only after return to IDLE.
REQ-030 SHALL cover: rst_n asserted in WAIT -> o_redirect_valid drops immediately, counters 0; counters preloaded to 0xFFFFFFFF by forcing -> further mispredicts keep 0xFFFFFFFF.

Source files
------------

// File: rtl/core_ex_bjp_resolve_pkg.sv
// ----------------------------------------------------------------------------
// core_ex_bjp_resolve_pkg
//   Shared definitions for the branch/jump resolve stage: datapath width,
//   branch condition (funct3) codes, resolve FSM state encoding and a
//   saturating counter increment helper.
// ----------------------------------------------------------------------------
package core_ex_bjp_resolve_pkg;

    localparam int CORE_XLEN = 32;

    // Byte distance to the sequential next instruction.
    localparam logic [CORE_XLEN-1:0] PC_STEP = CORE_XLEN'(4);

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } funct3_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } bjp_state_e;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/core_bjp_cmp.sv
// ----------------------------------------------------------------------------
// core_bjp_cmp
//   Pure combinational branch condition evaluation.
//   Ports:
//     rs1, rs2 : operands
//     funct3   : branch condition code
//     taken    : condition holds (codes 010/011 are never taken)
// ----------------------------------------------------------------------------
module core_bjp_cmp
    import core_ex_bjp_resolve_pkg::*;
(
    input  logic [CORE_XLEN-1:0] rs1,
    input  logic [CORE_XLEN-1:0] rs2,
    input  logic [2:0]           funct3,
    output logic                 taken
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (rs1 == rs2);
    assign lt_s = ($signed(rs1) < $signed(rs2));
    assign lt_u = (rs1 < rs2);

    always_comb begin
        // NOTE: default assigned first so every path drives taken; without
        // it an unlisted funct3 would hold the old value and infer a latch.
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = eq;
            F3_BNE:  taken = !eq;
            F3_BLT:  taken = lt_s;
            F3_BGE:  taken = !lt_s;
            F3_BLTU: taken = lt_u;
            F3_BGEU: taken = !lt_u;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/core_ex_bjp_resolve.sv
// ----------------------------------------------------------------------------
// core_ex_bjp_resolve
//   Execute-stage resolution of jal / jalr / conditional branches. Computes
//   the actual next PC, compares it with the fetch prediction and, on a
//   mispredict, issues a redirect to fetch plus a one-cycle flush. Results
//   appear one cycle after acceptance.
//   Ports:
//     clk, rst_n                      : clock, async active-low reset
//     i_valid / i_ready               : request handshake (ready only in IDLE)
//     i_pc, i_bj_imm, i_rs1, i_rs2    : operands
//     i_flag_jal/jalr/branch, i_funct3: op class and branch condition
//     i_pred_pc                       : predicted next PC
//     o_redirect_valid/pc, i_redirect_ready : redirect handshake to fetch
//     o_flush                         : squash younger ops (one cycle)
//     o_res_valid/taken/link, o_misalign : registered result
//     o_cnt_branch, o_cnt_mispred     : saturating performance counters
// ----------------------------------------------------------------------------
module core_ex_bjp_resolve
    import core_ex_bjp_resolve_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [CORE_XLEN-1:0] i_pc,
    input  logic                 i_flag_jal,
    input  logic                 i_flag_jalr,
    input  logic                 i_flag_branch,
    input  logic [CORE_XLEN-1:0] i_bj_imm,
    input  logic [2:0]           i_funct3,
    input  logic [CORE_XLEN-1:0] i_rs1,
    input  logic [CORE_XLEN-1:0] i_rs2,
    input  logic [CORE_XLEN-1:0] i_pred_pc,
    output logic                 o_redirect_valid,
    output logic [CORE_XLEN-1:0] o_redirect_pc,
    input  logic                 i_redirect_ready,
    output logic                 o_flush,
    output logic                 o_res_valid,
    output logic                 o_res_taken,
    output logic [CORE_XLEN-1:0] o_res_link,
    output logic                 o_misalign,
    output logic [31:0]          o_cnt_branch,
    output logic [31:0]          o_cnt_mispred
);

    bjp_state_e state_q;
    bjp_state_e state_nxt;

    logic                 cmp_taken;
    logic                 any_flag;
    logic                 taken;
    logic                 mispred;
    logic                 accept;
    logic [CORE_XLEN-1:0] link;
    logic [CORE_XLEN-1:0] jalr_sum;
    logic [CORE_XLEN-1:0] target;
    logic [CORE_XLEN-1:0] next_pc;

    core_bjp_cmp u_cmp (
        .rs1    (i_rs1),
        .rs2    (i_rs2),
        .funct3 (i_funct3),
        .taken  (cmp_taken)
    );

    // ------------------------------------------------------------------
    // Resolve datapath. Flag priority: jal > jalr > branch.
    // ------------------------------------------------------------------
    assign link     = i_pc + PC_STEP;
    assign jalr_sum = i_rs1 + i_bj_imm;
    assign any_flag = i_flag_jal | i_flag_jalr | i_flag_branch;

    always_comb begin
        taken  = cmp_taken;
        target = i_pc + i_bj_imm;
        if (i_flag_jal) begin
            taken = 1'b1;
        end else if (i_flag_jalr) begin
            taken  = 1'b1;
            target = {jalr_sum[CORE_XLEN-1:1], 1'b0};
        end
        next_pc = taken ? target : link;
        mispred = (next_pc != i_pred_pc);
    end

    // ------------------------------------------------------------------
    // FSM: IDLE accepts requests; WAIT holds a redirect until fetch takes it.
    // ------------------------------------------------------------------
    assign accept = i_valid && i_ready;

    always_comb begin
        state_nxt = state_q;
        i_ready   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                i_ready = 1'b1;
                if (i_valid && any_flag && mispred) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_redirect_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            o_redirect_valid <= 1'b0;
            o_redirect_pc    <= '0;
            o_flush          <= 1'b0;
            o_res_valid      <= 1'b0;
            o_res_taken      <= 1'b0;
            o_res_link       <= '0;
            o_misalign       <= 1'b0;
            o_cnt_branch     <= '0;
            o_cnt_mispred    <= '0;
        end else begin
            state_q     <= state_nxt;
            o_res_valid <= 1'b0;
            o_flush     <= 1'b0;

            if (accept && any_flag) begin
                o_res_valid  <= 1'b1;
                o_res_taken  <= taken;
                o_res_link   <= link;
                o_misalign   <= taken & target[1];
                o_cnt_branch <= sat_inc(o_cnt_branch);
                if (mispred) begin
                    o_redirect_valid <= 1'b1;
                    o_redirect_pc    <= next_pc;
                    o_flush          <= 1'b1;
                    o_cnt_mispred    <= sat_inc(o_cnt_mispred);
                end
            end else if (state_q == ST_WAIT && i_redirect_ready) begin
                // Handshake completes this cycle; redirect drops with IDLE.
                o_redirect_valid <= 1'b0;
            end
        end
    end

endmodule
